// File: rtl/fetch_stage.sv
// Instruction fetch stage: owns the PC, a one-word hold buffer for fetches that
// return while decode is stalled, and the IF/ID pipeline register.
module fetch_stage #(
   parameter logic [31:0] PC_RESET = 32'h0000_0000
) (
   input  logic        CLK,
   input  logic        RST,
   input  logic        enable_ID,
   input  logic        flush_ID,
   input  logic        redirect,
   input  logic [31:0] redirect_pc,
   output logic        iren,
   output logic [31:0] iaddr,
   input  logic        ihit,
   input  logic [31:0] iload,
   output logic [31:0] instr_ID,
   output logic [31:0] npc_ID,
   output logic        valid_ID,
   output logic        fsm_state
);

   // Handshake: the memory word is consumed on any rising edge where iren=1 and
   // ihit=1, unless a redirect or flush in the same cycle discards it.
   // fsm_state: 0 = FETCH (iren high), 1 = HELD (word parked in hold_buf).

   typedef enum logic {
      FETCH = 1'b0,
      HELD  = 1'b1
   } state_t;

   localparam logic [31:0] ALIGN_MASK = 32'hFFFF_FFFC;

   state_t      state;
   state_t      state_d;
   logic [31:0] pc;
   logic [31:0] pc_d;
   logic [31:0] pc_plus4;
   logic [31:0] hold_buf;
   logic [31:0] buf_d;
   logic        ifid_we;
   logic [31:0] instr_d;
   logic [31:0] npc_d;
   logic        valid_d;

   assign pc_plus4 = pc + 32'd4;

   // State register
   always_ff @(posedge CLK) begin
      if (RST) begin
         state <= FETCH;
      end else begin
         state <= state_d;
      end
   end

   // Next-state logic; a flush leaves the state alone so a parked word survives it.
   always_comb begin
      state_d = state;
      if (redirect) begin
         state_d = FETCH;
      end else if (!flush_ID) begin
         case (state)
            FETCH: if (ihit && !enable_ID) state_d = HELD;
            HELD:  if (enable_ID)          state_d = FETCH;
            default: state_d = FETCH;
         endcase
      end
   end

   // Output logic
   always_comb begin
      iren      = (state == FETCH);
      iaddr     = pc & ALIGN_MASK;
      fsm_state = state;
   end

   // Datapath next values. Defaults describe a bubble with ifid_we low (hold).
   always_comb begin
      pc_d    = pc;
      buf_d   = hold_buf;
      ifid_we = 1'b0;
      instr_d = 32'h0;
      npc_d   = 32'h0;
      valid_d = 1'b0;
      if (redirect) begin
         pc_d    = redirect_pc & ALIGN_MASK;
         buf_d   = 32'h0;
         ifid_we = 1'b1;
      end else if (flush_ID) begin
         ifid_we = 1'b1;
      end else if (state == FETCH) begin
         if (ihit && enable_ID) begin
            ifid_we = 1'b1;
            instr_d = iload;
            npc_d   = pc_plus4;
            valid_d = 1'b1;
            pc_d    = pc_plus4;
         end else if (ihit) begin
            buf_d = iload;
         end else if (enable_ID) begin
            ifid_we = 1'b1;
         end
      end else if (enable_ID) begin
         ifid_we = 1'b1;
         instr_d = hold_buf;
         npc_d   = pc_plus4;
         valid_d = 1'b1;
         pc_d    = pc_plus4;
      end
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         pc       <= PC_RESET;
         hold_buf <= 32'h0;
      end else begin
         pc       <= pc_d;
         hold_buf <= buf_d;
      end
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         instr_ID <= 32'h0;
         npc_ID   <= 32'h0;
         valid_ID <= 1'b0;
      end else if (ifid_we) begin
         instr_ID <= instr_d;
         npc_ID   <= npc_d;
         valid_ID <= valid_d;
      end
   end

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed vector table for the scripted scenarios, then
// randomized traffic checked against an issue-oriented reference model.
module tb_fetch_stage;

   logic        clk;
   logic        rst;
   logic        enable_id;
   logic        flush_id;
   logic        redirect;
   logic [31:0] redirect_pc;
   logic        iren;
   logic [31:0] iaddr;
   logic        ihit;
   logic [31:0] iload;
   logic [31:0] instr_id;
   logic [31:0] npc_id;
   logic        valid_id;
   logic        fsm_state;

   int pass_cnt  = 0;
   int total_cnt = 0;

   fetch_stage #(.PC_RESET(32'h0000_0000)) dut (
      .CLK        (clk),
      .RST        (rst),
      .enable_ID  (enable_id),
      .flush_ID   (flush_id),
      .redirect   (redirect),
      .redirect_pc(redirect_pc),
      .iren       (iren),
      .iaddr      (iaddr),
      .ihit       (ihit),
      .iload      (iload),
      .instr_ID   (instr_id),
      .npc_ID     (npc_id),
      .valid_ID   (valid_id),
      .fsm_state  (fsm_state)
   );

   // Clock
   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        rst;
      logic        redir;
      logic [31:0] rpc;
      logic        flush;
      logic        en;
      logic        hit;
      logic [31:0] load;
      logic        e_iren;
      logic [31:0] e_iaddr;
      logic [31:0] e_instr;
      logic [31:0] e_npc;
      logic        e_valid;
   } vec_t;

   vec_t vecs[$];

   function automatic vec_t mk(input logic r, input logic rd, input logic [31:0] rp,
                               input logic fl, input logic en, input logic ht,
                               input logic [31:0] ld, input logic e_ir,
                               input logic [31:0] e_ia, input logic [31:0] e_in,
                               input logic [31:0] e_np, input logic e_v);
      vec_t v;
      v.rst = r; v.redir = rd; v.rpc = rp; v.flush = fl; v.en = en; v.hit = ht;
      v.load = ld; v.e_iren = e_ir; v.e_iaddr = e_ia; v.e_instr = e_in;
      v.e_npc = e_np; v.e_valid = e_v;
      return v;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total_cnt++;
      if (act === exp) pass_cnt++;
      else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
   endtask

   // Driver: inputs change on the falling edge, outputs sampled 1 after rising edge
   task automatic drive(input logic r, input logic rd, input logic [31:0] rp,
                        input logic fl, input logic en, input logic ht,
                        input logic [31:0] ld);
      @(negedge clk);
      rst = r; redirect = rd; redirect_pc = rp; flush_id = fl;
      enable_id = en; ihit = ht; iload = ld;
      @(posedge clk);
      #1;
   endtask

   // Reference model: the stage either has a parked word or not; a word issues
   // whenever decode accepts and one is available (parked first, else memory).
   logic [31:0] m_pc;
   logic        m_parked;
   logic [31:0] m_buf;
   logic [31:0] m_instr;
   logic [31:0] m_npc;
   logic        m_valid;

   task automatic model_step(input logic r, input logic rd, input logic [31:0] rp,
                             input logic fl, input logic en, input logic ht,
                             input logic [31:0] ld);
      logic        have;
      logic [31:0] word;
      if (r) begin
         m_pc = 32'h0; m_parked = 1'b0; m_buf = 32'h0;
         m_instr = 32'h0; m_npc = 32'h0; m_valid = 1'b0;
      end else if (rd) begin
         m_pc = {rp[31:2], 2'b00}; m_parked = 1'b0;
         m_instr = 32'h0; m_npc = 32'h0; m_valid = 1'b0;
      end else if (fl) begin
         m_instr = 32'h0; m_npc = 32'h0; m_valid = 1'b0;
      end else if (!en) begin
         if (!m_parked && ht) begin
            m_parked = 1'b1; m_buf = ld;
         end
      end else begin
         have = m_parked || ht;
         word = m_parked ? m_buf : ld;
         if (have) begin
            m_instr = word; m_npc = m_pc + 32'd4; m_valid = 1'b1;
            m_pc = m_pc + 32'd4; m_parked = 1'b0;
         end else begin
            m_instr = 32'h0; m_npc = 32'h0; m_valid = 1'b0;
         end
      end
   endtask

   initial begin
      rst = 1'b1; redirect = 1'b0; redirect_pc = 32'h0; flush_id = 1'b0;
      enable_id = 1'b0; ihit = 1'b0; iload = 32'h0;

      //            rst rd rpc           fl en ht load           iren iaddr          instr          npc           v
      vecs.push_back(mk(1, 0, 32'h0,        0, 0, 0, 32'h0,        1, 32'h0000_0000, 32'h0,         32'h0,        0));
      vecs.push_back(mk(0, 0, 32'h0,        0, 1, 1, 32'h2001_0001, 1, 32'h0000_0004, 32'h2001_0001, 32'h4,        1));
      vecs.push_back(mk(0, 0, 32'h0,        0, 1, 1, 32'h2002_0002, 1, 32'h0000_0008, 32'h2002_0002, 32'h8,        1));
      // stall with a word returned at PC=8
      vecs.push_back(mk(0, 0, 32'h0,        0, 0, 1, 32'hAAAA_0008, 0, 32'h0000_0008, 32'h2002_0002, 32'h8,        1));
      vecs.push_back(mk(0, 0, 32'h0,        0, 0, 1, 32'hDEAD_0001, 0, 32'h0000_0008, 32'h2002_0002, 32'h8,        1));
      vecs.push_back(mk(0, 0, 32'h0,        0, 0, 0, 32'hDEAD_0002, 0, 32'h0000_0008, 32'h2002_0002, 32'h8,        1));
      vecs.push_back(mk(0, 0, 32'h0,        0, 1, 1, 32'hDEAD_0003, 1, 32'h0000_000C, 32'hAAAA_0008, 32'hC,        1));
      // flush with a hit at PC=0x10
      vecs.push_back(mk(0, 0, 32'h0,        0, 1, 1, 32'h1111_000C, 1, 32'h0000_0010, 32'h1111_000C, 32'h10,       1));
      vecs.push_back(mk(0, 0, 32'h0,        1, 1, 1, 32'hBAD0_0010, 1, 32'h0000_0010, 32'h0,         32'h0,        0));
      vecs.push_back(mk(0, 0, 32'h0,        0, 1, 1, 32'h2222_0010, 1, 32'h0000_0014, 32'h2222_0010, 32'h14,       1));
      // redirect while HELD
      vecs.push_back(mk(0, 0, 32'h0,        0, 0, 1, 32'hCCCC_0014, 0, 32'h0000_0014, 32'h2222_0010, 32'h14,       1));
      vecs.push_back(mk(0, 1, 32'h0000_0043, 0, 0, 0, 32'h0,        1, 32'h0000_0040, 32'h0,         32'h0,        0));
      vecs.push_back(mk(0, 0, 32'h0,        0, 1, 0, 32'h0,        1, 32'h0000_0040, 32'h0,         32'h0,        0));
      vecs.push_back(mk(0, 0, 32'h0,        0, 1, 1, 32'h3333_0040, 1, 32'h0000_0044, 32'h3333_0040, 32'h44,       1));
      // flush while HELD keeps the parked word
      vecs.push_back(mk(0, 0, 32'h0,        0, 0, 1, 32'hDDDD_0044, 0, 32'h0000_0044, 32'h3333_0040, 32'h44,       1));
      vecs.push_back(mk(0, 0, 32'h0,        1, 1, 1, 32'hBAD0_0044, 0, 32'h0000_0044, 32'h0,         32'h0,        0));
      vecs.push_back(mk(0, 0, 32'h0,        0, 1, 0, 32'h0,        1, 32'h0000_0048, 32'hDDDD_0044, 32'h48,       1));
      // wrap at the top of the address space
      vecs.push_back(mk(0, 1, 32'hFFFF_FFFE, 0, 1, 0, 32'h0,        1, 32'hFFFF_FFFC, 32'h0,         32'h0,        0));
      vecs.push_back(mk(0, 0, 32'h0,        0, 1, 1, 32'h4444_FFFC, 1, 32'h0000_0000, 32'h4444_FFFC, 32'h0,        1));
      vecs.push_back(mk(0, 0, 32'h0,        0, 0, 1, 32'h5555_0000, 0, 32'h0000_0000, 32'h4444_FFFC, 32'h0,        1));
      // reset beats redirect/flush/hit while HELD
      vecs.push_back(mk(1, 1, 32'h0000_0100, 1, 1, 1, 32'h9999_9999, 1, 32'h0000_0000, 32'h0,         32'h0,        0));
      vecs.push_back(mk(0, 0, 32'h0,        0, 1, 0, 32'h0,        1, 32'h0000_0000, 32'h0,         32'h0,        0));
      vecs.push_back(mk(0, 0, 32'h0,        0, 1, 1, 32'h6666_0000, 1, 32'h0000_0004, 32'h6666_0000, 32'h4,        1));
      // redirect drops a same-cycle hit; then idle hold and ihit=0 bubble
      vecs.push_back(mk(0, 1, 32'h0000_0200, 0, 1, 1, 32'h7777_0004, 1, 32'h0000_0200, 32'h0,         32'h0,        0));
      vecs.push_back(mk(0, 0, 32'h0,        0, 1, 1, 32'h8888_0200, 1, 32'h0000_0204, 32'h8888_0200, 32'h204,      1));
      vecs.push_back(mk(0, 0, 32'h0,        0, 0, 0, 32'h0,        1, 32'h0000_0204, 32'h8888_0200, 32'h204,      1));
      vecs.push_back(mk(0, 0, 32'h0,        0, 1, 0, 32'h0,        1, 32'h0000_0204, 32'h0,         32'h0,        0));

      foreach (vecs[i]) begin
         drive(vecs[i].rst, vecs[i].redir, vecs[i].rpc, vecs[i].flush,
               vecs[i].en, vecs[i].hit, vecs[i].load);
         check($sformatf("vec%0d iren", i),     {31'h0, iren},      {31'h0, vecs[i].e_iren});
         check($sformatf("vec%0d state", i),    {31'h0, fsm_state}, {31'h0, ~vecs[i].e_iren});
         check($sformatf("vec%0d iaddr", i),    iaddr,              vecs[i].e_iaddr);
         check($sformatf("vec%0d instr_ID", i), instr_id,           vecs[i].e_instr);
         check($sformatf("vec%0d npc_ID", i),   npc_id,             vecs[i].e_npc);
         check($sformatf("vec%0d valid_ID", i), {31'h0, valid_id},  {31'h0, vecs[i].e_valid});
      end

      // Randomized traffic, started from reset so model and DUT agree
      model_step(1, 0, 32'h0, 0, 0, 0, 32'h0);
      drive(1, 0, 32'h0, 0, 0, 0, 32'h0);
      for (int c = 0; c < 2000; c++) begin
         logic        r_rst, r_rd, r_fl, r_en, r_ht;
         logic [31:0] r_rpc, r_ld;
         r_rst = ($urandom_range(0, 63) == 0);
         r_rd  = ($urandom_range(0, 11) == 0);
         r_fl  = ($urandom_range(0, 9) == 0);
         r_en  = ($urandom_range(0, 3) != 0);
         r_ht  = ($urandom_range(0, 9) < 6);
         r_ld  = $urandom;
         r_rpc = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFE0 | ($urandom & 32'h1F)) : $urandom;
         model_step(r_rst, r_rd, r_rpc, r_fl, r_en, r_ht, r_ld);
         drive(r_rst, r_rd, r_rpc, r_fl, r_en, r_ht, r_ld);
         check("rand iren",     {31'h0, iren},     {31'h0, ~m_parked});
         check("rand iaddr",    iaddr,             {m_pc[31:2], 2'b00});
         check("rand instr_ID", instr_id,          m_instr);
         check("rand npc_ID",   npc_id,            m_npc);
         check("rand valid_ID", {31'h0, valid_id}, {31'h0, m_valid});
      end

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 Parameter: PC_RESET, default 32'h0000_0000, value loaded into the PC on reset.
REQ-002 Port: CLK  input  1  rising-edge clock for all state.
REQ-003 Port: RST  input  1  reset, synchronous, active-high.
REQ-004 Port: enable_ID  input  1  from hazard unit; 0 = hold the IF/ID register and the PC.
REQ-005 Port: flush_ID  input  1  from hazard unit; 1 = load a bubble into IF/ID.
REQ-006 Port: redirect  input  1  jump/JR/branch resolved taken; PC takes redirect_pc.
REQ-007 Port: redirect_pc  input  32  target address.
REQ-008 Port: iren  output  1  instruction memory read enable.
REQ-009 Port: iaddr  output  32  instruction memory address.
REQ-010 Port: ihit  input  1  instruction memory data valid this cycle.
REQ-011 Port: iload  input  32  instruction word, valid when ihit=1.
REQ-012 Port: instr_ID  output  32  IF/ID instruction word, 0 when bubble.
REQ-013 Port: npc_ID  output  32  IF/ID PC+4 of instr_ID.
REQ-014 Port: valid_ID  output  1  IF/ID holds a real instruction.

Function
REQ-015 The block SHALL hold a 32-bit PC, a 32-bit hold buffer and a 2-state FSM {FETCH, HELD}.
REQ-016 The block SHALL drive iaddr = {PC[31:2], 2'b00} combinationally in both states.
REQ-017 The block SHALL drive iren=1 in FETCH and iren=0 in HELD.
REQ-018 Per-cycle priority SHALL be: RST > redirect > flush_ID > enable_ID.
REQ-019 If redirect=1 in any state, the block SHALL: load PC <= {redirect_pc[31:2],2'b00}; discard any same-cycle ihit and the hold buffer; load a bubble into IF/ID; go to FETCH. These actions SHALL apply regardless of enable_ID.
REQ-020 If flush_ID=1 and redirect=0, the block SHALL load a bubble into IF/ID and leave the PC unchanged.
REQ-021 Under REQ-020, FETCH with ihit=1 SHALL drop iload and refetch the same PC; HELD SHALL retain the buffer and stay HELD.
REQ-022 In FETCH, when ihit=1, enable_ID=1 and there is no redirect/flush, the block SHALL load IF/ID <= {iload, PC+4, valid=1} and set PC <= PC+4.
REQ-023 In FETCH, when ihit=1, enable_ID=0 and there is no redirect/flush, the block SHALL capture iload into the buffer, leave the PC and IF/ID unchanged, and go to HELD.
REQ-024 In FETCH, when ihit=0 and enable_ID=1 and there is no redirect/flush, the block SHALL load a bubble into IF/ID and leave the PC unchanged.
REQ-025 In FETCH, when ihit=0 and enable_ID=0, all state SHALL be unchanged.
REQ-026 In HELD, when enable_ID=1 and there is no redirect/flush, the block SHALL load IF/ID <= {buffer, PC+4, 1}, set PC <= PC+4, and go to FETCH.
REQ-027 In HELD, when enable_ID=0, all state SHALL be unchanged; ihit SHALL be ignored.
REQ-028 A bubble SHALL be instr_ID=0, npc_ID=0, valid_ID=0.
REQ-029 PC+4 SHALL wrap modulo 2^32 (32'hFFFF_FFFC -> 32'h0000_0000).
REQ-030 Fetch latency SHALL be 1 cycle: an instruction accepted at edge N SHALL appear on the IF/ID outputs after edge N.

Reset
REQ-031 On RST=1 at a clock edge, the block SHALL set PC=PC_RESET, state=FETCH, buffer=0, and IF/ID to a bubble.
REQ-032 Reset SHALL override redirect, flush_ID, enable_ID and ihit in the same cycle, including when HELD.
REQ-033 After reset, iren SHALL be 1 and iaddr SHALL be PC_RESET.

Verification
REQ-034 Streaming: reset, ihit=1 every cycle, enable_ID=1, iload=0x20010001,0x20020002 -> instr_ID shows them on consecutive cycles; npc_ID = 4, 8.
REQ-035 Stall: ihit=1 at PC=8 with enable_ID=0 for 3 cycles -> iren=0 and IF/ID held for 3 cycles; on enable_ID=1, instr_ID = buffered word, npc_ID = 0xC.
REQ-036 Redirect in HELD: redirect=1, redirect_pc=0x0000_0043 -> next cycle iaddr=0x40, state=FETCH, valid_ID=0, buffered word never issued.
REQ-037 Flush without redirect: flush_ID=1, ihit=1 at PC=0x10 -> valid_ID=0; iaddr remains 0x10 and is refetched.
REQ-038 Wrap and reset: PC=0xFFFF_FFFC with ihit=1 -> npc_ID=0 and iaddr=0; then RST=1 concurrent with redirect=1 -> iaddr=PC_RESET.
